// File: rtl/rv32i_mc_core.sv
// Multi-cycle RV32I core: FETCH -> DECODE -> EXECUTE -> [MEM] -> WB, with req/ready memory
// handshakes, byte-lane loads/stores, and sticky HALT/TRAP terminal states.
module rv32i_mc_core #(
  parameter int          PC_WIDTH    = 8,
  parameter int unsigned RESET_PC    = 0,
  parameter bit          TRAP_ON_MIS = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [31:0]         dmem_addr,
  output logic [3:0]          dmem_be,
  output logic [31:0]         dmem_wdata,
  input  logic                dmem_ready,
  input  logic [31:0]         dmem_rdata,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic                trap
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DEC = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3,
                         S_WB = 3'd4, S_HALT = 3'd5, S_TRAP = 3'd6;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67,
                         OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13,
                         OP_REG = 7'h33, OP_FENCE = 7'h0F, OP_SYS = 7'h73;

  logic [2:0]          r_state;
  logic [PC_WIDTH-1:0] r_pc, r_npc;
  logic [31:0]         r_ir, r_rs1v, r_rs2v, r_imm, r_res, r_ldv;
  logic [31:0]         r_rf [32];

  logic [6:0]  w_op;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic        w_f7b5;
  logic [31:0] w_imm, w_opb, w_alu, w_addr, w_res, w_ld;
  logic        w_legal, w_wen, w_take, w_mis_mem;
  logic [PC_WIDTH-1:0] w_pc4, w_npc;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_be_st;
  logic [31:0] w_wd_st;

  assign w_op   = r_ir[6:0];
  assign w_rd   = r_ir[11:7];
  assign w_f3   = r_ir[14:12];
  assign w_rs1  = r_ir[19:15];
  assign w_rs2  = r_ir[24:20];
  assign w_f7b5 = r_ir[30];
  assign w_addr = r_rs1v + r_imm;
  assign w_pc4  = r_pc + PC_WIDTH'(4);

  always_comb begin
    w_imm   = {{20{r_ir[31]}}, r_ir[31:20]};
    w_legal = 1'b1;
    w_wen   = 1'b0;
    case (w_op)
      OP_LUI, OP_AUIPC: begin w_imm = {r_ir[31:12], 12'b0}; w_wen = 1'b1; end
      OP_JAL:  begin
        w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
        w_wen = 1'b1;
      end
      OP_BR:   w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
      OP_ST:   w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      OP_JALR, OP_LD, OP_IMM, OP_REG: w_wen = 1'b1;
      OP_FENCE, OP_SYS: ;
      default: w_legal = 1'b0;
    endcase
  end

  // SUB only exists for register-register ops; bit 30 of an ADDI immediate is just data.
  always_comb begin
    w_opb = (w_op == OP_REG) ? r_rs2v : r_imm;
    case (w_f3)
      3'd0: w_alu = (w_op == OP_REG && w_f7b5) ? r_rs1v - w_opb : r_rs1v + w_opb;
      3'd1: w_alu = r_rs1v << w_opb[4:0];
      3'd2: w_alu = {31'b0, $signed(r_rs1v) < $signed(w_opb)};
      3'd3: w_alu = {31'b0, r_rs1v < w_opb};
      3'd4: w_alu = r_rs1v ^ w_opb;
      3'd5: w_alu = w_f7b5 ? 32'($signed(r_rs1v) >>> w_opb[4:0]) : r_rs1v >> w_opb[4:0];
      3'd6: w_alu = r_rs1v | w_opb;
      default: w_alu = r_rs1v & w_opb;
    endcase
    case (w_f3)
      3'd0: w_take = r_rs1v == r_rs2v;
      3'd1: w_take = r_rs1v != r_rs2v;
      3'd4: w_take = $signed(r_rs1v) < $signed(r_rs2v);
      3'd5: w_take = $signed(r_rs1v) >= $signed(r_rs2v);
      3'd6: w_take = r_rs1v < r_rs2v;
      3'd7: w_take = r_rs1v >= r_rs2v;
      default: w_take = 1'b0;
    endcase
    case (w_op)
      OP_LUI:          w_res = r_imm;
      OP_AUIPC:        w_res = 32'(r_pc) + r_imm;
      OP_JAL, OP_JALR: w_res = 32'(w_pc4);
      OP_LD, OP_ST:    w_res = w_addr;
      default:         w_res = w_alu;
    endcase
    w_npc = w_pc4;
    if (w_op == OP_JAL || (w_op == OP_BR && w_take)) w_npc = r_pc + r_imm[PC_WIDTH-1:0];
    if (w_op == OP_JALR) w_npc = w_addr[PC_WIDTH-1:0] & ~PC_WIDTH'(1);
    case (w_f3[1:0])
      2'd1:    w_mis_mem = w_addr[0];
      2'd2:    w_mis_mem = |w_addr[1:0];
      default: w_mis_mem = 1'b0;
    endcase
  end

  // Store lanes and load extraction both key off the registered byte address.
  always_comb begin
    case (w_f3[1:0])
      2'd0:    begin w_be_st = 4'b0001 << r_res[1:0];        w_wd_st = {4{r_rs2v[7:0]}};  end
      2'd1:    begin w_be_st = 4'b0011 << {r_res[1], 1'b0};  w_wd_st = {2{r_rs2v[15:0]}}; end
      default: begin w_be_st = 4'b1111;                      w_wd_st = r_rs2v;            end
    endcase
    case (r_res[1:0])
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_res[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (w_f3)
      3'd0:    w_ld = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_ld = {{16{w_half[15]}}, w_half};
      3'd4:    w_ld = {24'b0, w_byte};
      3'd5:    w_ld = {16'b0, w_half};
      default: w_ld = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= PC_WIDTH'(RESET_PC);
      r_npc   <= PC_WIDTH'(RESET_PC);
      r_ir    <= '0;
      r_rs1v  <= '0;
      r_rs2v  <= '0;
      r_imm   <= '0;
      r_res   <= '0;
      r_ldv   <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (imem_ready) begin r_ir <= imem_rdata; r_state <= S_DEC; end
        S_DEC: begin
          r_rs1v <= (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
          r_rs2v <= (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2];
          r_imm  <= w_imm;
          if (!w_legal)            r_state <= S_TRAP;
          else if (w_op == OP_SYS) r_state <= S_HALT;
          else                     r_state <= S_EXE;
        end
        S_EXE: begin
          r_res <= w_res;
          r_npc <= TRAP_ON_MIS ? w_npc : {w_npc[PC_WIDTH-1:2], 2'b00};
          if (TRAP_ON_MIS && w_npc[1])                 r_state <= S_TRAP;
          else if (w_op == OP_LD || w_op == OP_ST)     r_state <= (TRAP_ON_MIS && w_mis_mem) ? S_TRAP : S_MEM;
          else                                         r_state <= S_WB;
        end
        S_MEM: if (dmem_ready) begin r_ldv <= w_ld; r_state <= S_WB; end
        S_WB:  begin r_pc <= r_npc; r_state <= S_FETCH; end
        default: r_state <= r_state;
      endcase
    end
  end

  // A reset landing on a WB cycle forces FETCH asynchronously, so the write never happens.
  always_ff @(posedge clk) begin
    if (r_state == S_WB && w_wen && w_rd != 5'd0)
      r_rf[w_rd] <= (w_op == OP_LD) ? r_ldv : r_res;
  end

  assign imem_req   = rst_n && (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign dmem_req   = (r_state == S_MEM);
  assign dmem_we    = dmem_req && (w_op == OP_ST);
  assign dmem_addr  = dmem_req ? r_res : '0;
  assign dmem_be    = dmem_req ? ((w_op == OP_ST) ? w_be_st : 4'hF) : 4'h0;
  assign dmem_wdata = dmem_we ? w_wd_st : '0;
  assign halted     = (r_state == S_HALT);
  assign trap       = (r_state == S_TRAP);
endmodule

// File: tb/tb_rv32i_mc_core.sv
// Directed bench for rv32i_mc_core: small imem/dmem models, store/fetch loggers, and
// hand-computed expectations for ALU, load/store lanes, branches, stalls, traps and reset.
module tb_rv32i_mc_core;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, halted, trap;
  logic [7:0]  imem_addr, pc;
  logic [31:0] imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        imem_en = 1'b1, dmem_en = 1'b1, clr = 1'b1;
  logic [31:0] imem [64];
  logic [31:0] dmem [16];
  logic [7:0]  ftr [32];
  logic [31:0] st_a [8], st_d [8];
  logic [3:0]  st_b [8];
  int          fcnt, scnt, total = 0, bad = 0, n;
  logic        dseen;

  localparam logic [6:0] LD = 7'h03, IMM = 7'h13, JALR = 7'h67, LUI = 7'h37, AUIPC = 7'h17;

  rv32i_mc_core dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc(pc), .halted(halted), .trap(trap)
  );

  always #5 clk = ~clk;
  assign imem_ready = imem_req & imem_en;
  assign imem_rdata = imem[imem_addr[7:2]];
  assign dmem_ready = dmem_req & dmem_en;
  assign dmem_rdata = dmem[dmem_addr[5:2]];

  always @(posedge clk) begin
    if (clr) begin
      fcnt <= 0; scnt <= 0; dseen <= 1'b0;
      for (int i = 0; i < 16; i++) dmem[i] <= '0;
    end else begin
      if (imem_req && imem_ready) begin
        if (fcnt < 32) ftr[fcnt] <= imem_addr;
        fcnt <= fcnt + 1;
      end
      if (dmem_req) dseen <= 1'b1;
      if (dmem_req && dmem_ready && dmem_we) begin
        if (scnt < 8) begin st_a[scnt] <= dmem_addr; st_b[scnt] <= dmem_be; st_d[scnt] <= dmem_wdata; end
        for (int b = 0; b < 4; b++)
          if (dmem_be[b]) dmem[dmem_addr[5:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
        scnt <= scnt + 1;
      end
    end
  end

  function automatic logic [31:0] ei(input logic [11:0] imm, input logic [4:0] rs1,
                                     input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] es(input logic [11:0] imm, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(input logic [12:0] imm, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] ej(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ireq", 32'(imem_req), 32'h0);
    chk("rst_dreq", 32'(dmem_req), 32'h0);
    chk("rst_be", 32'(dmem_be), 32'h0);
    chk("rst_flags", {30'b0, halted, trap}, 32'h0);
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic run_done(input int maxc, output int k);
    k = 0;
    while (!(halted || trap) && k < maxc) begin cyc(1); k++; end
  endtask

  initial begin
    // A: ALU, stores, byte loads, SB/SH lanes, ECALL
    do_reset();
    imem[0] = ei(12'd5, 5'd0, 3'd0, 5'd1, IMM);
    imem[1] = ei(-12'sd7, 5'd1, 3'd0, 5'd2, IMM);
    imem[2] = es(12'd4, 5'd2, 5'd0, 3'd2);
    imem[3] = ei(12'd7, 5'd0, 3'd0, 5'd3, LD);
    imem[4] = ei(12'd6, 5'd0, 3'd4, 5'd4, LD);
    imem[5] = es(12'd5, 5'd1, 5'd0, 3'd0);
    imem[6] = es(12'd8, 5'd3, 5'd0, 3'd2);
    imem[7] = es(12'd12, 5'd4, 5'd0, 3'd2);
    imem[8] = es(12'd2, 5'd1, 5'd0, 3'd1);
    imem[9] = 32'h0000_0073;
    rst_n = 1'b1;
    cyc(4); chk("A_pc4", 32'(pc), 32'h4);
    cyc(4); chk("A_pc8", 32'(pc), 32'h8);
    run_done(100, n);
    chk("A_cycles", n, 37);
    chk("A_halted", 32'(halted), 32'h1);
    chk("A_nst", scnt, 5);
    chk("A_sw_a", st_a[0], 32'h4);  chk("A_sw_be", 32'(st_b[0]), 32'hF); chk("A_sw_d", st_d[0], 32'hFFFF_FFFE);
    chk("A_sb_a", st_a[1], 32'h5);  chk("A_sb_be", 32'(st_b[1]), 32'h2); chk("A_sb_d", st_d[1], 32'h0505_0505);
    chk("A_lb", st_d[2], 32'hFFFF_FFFF);
    chk("A_lbu", st_d[3], 32'h0000_00FF);
    chk("A_sh_be", 32'(st_b[4]), 32'hC); chk("A_sh_d", st_d[4], 32'h0005_0005);
    chk("A_mem1", dmem[1], 32'hFFFF_05FE);
    chk("A_mem0", dmem[0], 32'h0005_0000);
    cyc(3);
    chk("A_hold_pc", 32'(pc), 32'h24);
    chk("A_hold_req", {30'b0, imem_req, dmem_req}, 32'h0);

    // B: branch/jump next-PC, JALR misaligned target
    do_reset();
    imem[0]  = ei(12'd1, 5'd0, 3'd0, 5'd1, IMM);
    imem[1]  = ej(21'd12, 5'd0);
    imem[2]  = ei(-12'sd1, 5'd1, 3'd0, 5'd1, IMM);
    imem[3]  = ej(21'd4, 5'd0);
    imem[4]  = eb(-13'sd8, 5'd0, 5'd1, 3'd1);
    imem[5]  = ei(12'h40, 5'd0, 3'd0, 5'd6, IMM);
    imem[6]  = eb(13'd8, 5'd0, 5'd6, 3'd0);
    imem[7]  = ei(-12'sd1, 5'd0, 3'd0, 5'd7, IMM);
    imem[8]  = ej(21'd12, 5'd5);
    imem[11] = eb(13'd8, 5'd0, 5'd7, 3'd4);
    imem[13] = eb(13'd8, 5'd0, 5'd7, 3'd6);
    imem[14] = eb(13'd8, 5'd7, 5'd0, 3'd5);
    imem[16] = eb(13'd8, 5'd7, 5'd0, 3'd7);
    imem[17] = es(12'd0, 5'd5, 5'd0, 3'd2);
    imem[18] = ei(12'd3, 5'd6, 3'd0, 5'd0, JALR);
    rst_n = 1'b1;
    run_done(200, n);
    chk("B_cycles", n, 64);
    chk("B_trap", 32'(trap), 32'h1);
    chk("B_pc", 32'(pc), 32'h48);
    chk("B_nfetch", fcnt, 16);
    begin
      logic [7:0] exp_tr [16] = '{8'h00, 8'h04, 8'h10, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                                  8'h1C, 8'h20, 8'h2C, 8'h34, 8'h38, 8'h40, 8'h44, 8'h48};
      for (int i = 0; i < 16; i++) chk($sformatf("B_tr%0d", i), 32'(ftr[i]), 32'(exp_tr[i]));
    end
    chk("B_link", st_d[0], 32'h24);

    // C: fetch stall then misaligned LW traps without a data request
    do_reset();
    imem_en = 1'b0;
    imem[0] = ei(12'd6, 5'd0, 3'd2, 5'd1, LD);
    rst_n = 1'b1;
    cyc(3);
    chk("C_stall_req", 32'(imem_req), 32'h1);
    chk("C_stall_addr", 32'(imem_addr), 32'h0);
    chk("C_stall_fcnt", fcnt, 0);
    imem_en = 1'b1;
    run_done(20, n);
    chk("C_cycles", n, 3);
    chk("C_trap", 32'(trap), 32'h1);
    chk("C_dseen", 32'(dseen), 32'h0);

    // D: reset mid-store, then LUI/AUIPC/SUB/SRAI/LH/LHU and x0 write
    do_reset();
    dmem_en = 1'b0;
    imem[0] = {20'h12345, 5'd8, LUI};
    imem[1] = es(12'd0, 5'd8, 5'd0, 3'd2);
    rst_n = 1'b1;
    n = 0;
    while (!dmem_req && n < 20) begin cyc(1); n++; end
    chk("D_req_lat", n, 7);
    cyc(2);
    chk("D_req_hold", {29'b0, dmem_req, dmem_we, imem_req}, 32'h6);
    chk("D_wd_hold", dmem_wdata, 32'h1234_5000);
    rst_n = 1'b0;
    #1;
    chk("D_rst_dreq", 32'(dmem_req), 32'h0);
    chk("D_rst_pc", 32'(pc), 32'h0);
    chk("D_rst_nst", scnt, 0);
    dmem_en = 1'b1;
    do_reset();
    imem[0]  = ei(12'd5, 5'd0, 3'd0, 5'd0, IMM);
    imem[1]  = {20'h00001, 5'd9, AUIPC};
    imem[2]  = {7'h20, 5'd9, 5'd0, 3'd0, 5'd10, 7'h33};
    imem[3]  = ei(12'h404, 5'd10, 3'd5, 5'd11, IMM);
    imem[4]  = es(12'd0, 5'd0, 5'd0, 3'd2);
    imem[5]  = es(12'd4, 5'd9, 5'd0, 3'd2);
    imem[6]  = es(12'd8, 5'd11, 5'd0, 3'd2);
    imem[7]  = ei(12'd8, 5'd0, 3'd1, 5'd12, LD);
    imem[8]  = ei(12'd8, 5'd0, 3'd5, 5'd13, LD);
    imem[9]  = es(12'd12, 5'd12, 5'd0, 3'd2);
    imem[10] = es(12'd16, 5'd13, 5'd0, 3'd2);
    imem[11] = 32'h0000_0073;
    rst_n = 1'b1;
    run_done(200, n);
    chk("D_cycles", n, 53);
    chk("D_halt", {30'b0, halted, trap}, 32'h2);
    chk("D_x0", st_d[0], 32'h0);
    chk("D_auipc", st_d[1], 32'h0000_1004);
    chk("D_srai", st_d[2], 32'hFFFF_FEFF);
    chk("D_lh", st_d[3], 32'hFFFF_FEFF);
    chk("D_lhu", st_d[4], 32'h0000_FEFF);
    cyc(3);
    chk("D_hold", {23'b0, imem_req, dmem_req, pc[6:0]}, 32'h2C);

    // E: PC wraps from 2**PC_WIDTH-4 to 0
    do_reset();
    imem[0]  = ej(21'h0FC, 5'd13);
    imem[63] = ei(12'd0, 5'd0, 3'd0, 5'd0, IMM);
    rst_n = 1'b1;
    cyc(4); chk("E_pcFC", 32'(pc), 32'hFC);
    cyc(4); chk("E_wrap", 32'(pc), 32'h0);
    chk("E_tr1", 32'(ftr[1]), 32'hFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
